// File: rtl/gemm_pkg.sv
// -----------------------------------------------------------------------------
// gemm_pkg
// Shared definitions for the systolic GEMM tile: default tile geometry and
// operand/accumulator widths, plus the controller state enumeration.
// No ports (package).
// -----------------------------------------------------------------------------
package gemm_pkg;

    localparam int DEF_M          = 4;
    localparam int DEF_N          = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 32;

    // Encoding is visible on the tile's debug state output:
    // 0 = IDLE, 1 = LOAD, 2 = FLUSH, 3 = DRAIN.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } gemm_state_e;

endpackage

// File: rtl/gemm_pe.sv
// -----------------------------------------------------------------------------
// gemm_pe
// One output-stationary processing element. Registers its A operand (and
// valid) toward the right neighbour and its B operand (and valid) toward the
// lower neighbour, and accumulates a*b into a local accumulator whenever the
// incoming operands are marked valid.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   clear_i         : zero the accumulator this cycle (start of a fresh job)
//   is_signed_i     : 1 = two's-complement operands, 0 = unsigned
//   a_i, a_valid_i  : A operand from the left
//   b_i, b_valid_i  : B operand from above
//   a_o, a_valid_o  : registered A operand to the right
//   b_o, b_valid_o  : registered B operand downward
//   acc_o           : accumulator value
// -----------------------------------------------------------------------------
module gemm_pe
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  is_signed_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic                  a_valid_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  b_valid_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic                  a_valid_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic                  b_valid_o,
    output logic [ACC_WIDTH-1:0]  acc_o
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic                  a_valid_q, b_valid_q;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;

    logic signed [PW-1:0]  prod_s;
    logic        [PW-1:0]  prod_u;
    logic [ACC_WIDTH-1:0]  prod_ext;

    // Operands are widened to the full product width before multiplying so the
    // product is exact; the size cast then sign- or zero-extends to ACC_WIDTH.
    always_comb begin
        prod_s = PW'($signed(a_i)) * PW'($signed(b_i));
        prod_u = PW'(a_i) * PW'(b_i);
        if (is_signed_i) begin
            prod_ext = ACC_WIDTH'(prod_s);
        end else begin
            prod_ext = ACC_WIDTH'(prod_u);
        end
    end

    // Accumulation wraps naturally modulo 2^ACC_WIDTH.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (a_valid_i && b_valid_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            acc_q     <= '0;
        end else begin
            a_q       <= a_i;
            b_q       <= b_i;
            a_valid_q <= a_valid_i;
            b_valid_q <= b_valid_i;
            acc_q     <= acc_d;
        end
    end

    assign a_o       = a_q;
    assign a_valid_o = a_valid_q;
    assign b_o       = b_q;
    assign b_valid_o = b_valid_q;
    assign acc_o     = acc_q;

endmodule

// File: rtl/systolic_gemm_tile.sv
// -----------------------------------------------------------------------------
// systolic_gemm_tile
// Output-stationary M x N systolic tile computing C = A x B (optionally
// accumulating onto the previous C). Each accepted beat carries column k of A
// and row k of B; after the beat marked last, the array is flushed and C is
// streamed out one row per handshake.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is a pure function of state; out_valid is held in DRAIN
// and the presented row does not change until it is accepted.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   in_valid/in_ready, in_a (col k of A), in_b (row k of B), in_last
//   is_signed, acc_keep : job mode, sampled on the first beat only
//   out_valid/out_ready, out_row (row r of C), out_last (row M-1)
//   dbg_state_o  : current controller state (see gemm_pkg encoding)
// -----------------------------------------------------------------------------
module systolic_gemm_tile
    import gemm_pkg::*;
#(
    parameter int M          = DEF_M,
    parameter int N          = DEF_N,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [M*DATA_WIDTH-1:0] in_a,
    input  logic [N*DATA_WIDTH-1:0] in_b,
    input  logic                    in_last,
    input  logic                    is_signed,
    input  logic                    acc_keep,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*ACC_WIDTH-1:0]  out_row,
    output logic                    out_last,
    output logic [1:0]              dbg_state_o
);

    localparam int CW = $clog2(M + N);
    localparam int RW = (M > 1) ? $clog2(M) : 1;

    gemm_state_e    state_q, state_d;
    logic [CW-1:0]  flush_cnt_q, flush_cnt_d;
    logic [RW-1:0]  row_q, row_d;
    logic           signed_q, signed_d;
    logic           fire;
    logic           clear_acc;

    // Systolic interconnect: *_h[i][j] / *_v[i][j] are the operands entering PE(i,j).
    logic [DATA_WIDTH-1:0] a_h  [M][N];
    logic                  av_h [M][N];
    logic [DATA_WIDTH-1:0] b_v  [M][N];
    logic                  bv_v [M][N];
    logic [ACC_WIDTH-1:0]  acc  [M][N];

    assign in_ready    = !reset && ((state_q == IDLE) || (state_q == LOAD));
    assign fire        = in_valid && in_ready;
    assign out_valid   = !reset && (state_q == DRAIN);
    assign out_last    = out_valid && (row_q == RW'(M - 1));
    assign dbg_state_o = state_q;

    // ---------------- controller ----------------
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        row_d       = row_q;
        signed_d    = signed_q;
        clear_acc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    signed_d    = is_signed;
                    clear_acc   = !acc_keep;
                    flush_cnt_d = '0;
                    state_d     = in_last ? FLUSH : LOAD;
                end
            end
            LOAD: begin
                if (fire && in_last) begin
                    flush_cnt_d = '0;
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                // The last beat needs M+N-1 cycles to reach PE(M-1,N-1).
                if (flush_cnt_q == CW'(M + N - 2)) begin
                    row_d   = '0;
                    state_d = DRAIN;
                end else begin
                    flush_cnt_d = flush_cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (row_q == RW'(M - 1)) begin
                        row_d   = '0;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            row_q       <= '0;
            signed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            row_q       <= row_d;
            signed_q    <= signed_d;
        end
    end

    // ---------------- input skew ----------------
    // Row i of A passes through i+1 registers (the first captures the accepted
    // beat), so A element i reaches PE(i,0) i cycles after element 0.
    for (genvar i = 0; i < M; i++) begin : g_a_skew
        logic [DATA_WIDTH-1:0] d_q [0:i];
        logic                  v_q [0:i];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s <= i; s++) begin
                    d_q[s] <= '0;
                    v_q[s] <= 1'b0;
                end
            end else begin
                d_q[0] <= in_a[i*DATA_WIDTH +: DATA_WIDTH];
                v_q[0] <= fire;
                for (int s = 1; s <= i; s++) begin
                    d_q[s] <= d_q[s-1];
                    v_q[s] <= v_q[s-1];
                end
            end
        end
        assign a_h[i][0]  = d_q[i];
        assign av_h[i][0] = v_q[i];
    end

    for (genvar j = 0; j < N; j++) begin : g_b_skew
        logic [DATA_WIDTH-1:0] d_q [0:j];
        logic                  v_q [0:j];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s <= j; s++) begin
                    d_q[s] <= '0;
                    v_q[s] <= 1'b0;
                end
            end else begin
                d_q[0] <= in_b[j*DATA_WIDTH +: DATA_WIDTH];
                v_q[0] <= fire;
                for (int s = 1; s <= j; s++) begin
                    d_q[s] <= d_q[s-1];
                    v_q[s] <= v_q[s-1];
                end
            end
        end
        assign b_v[0][j]  = d_q[j];
        assign bv_v[0][j] = v_q[j];
    end

    // ---------------- PE grid ----------------
    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DATA_WIDTH-1:0] a_nx, b_nx;
            logic                  a_nx_v, b_nx_v;

            gemm_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk         (clk),
                .reset       (reset),
                .clear_i     (clear_acc),
                .is_signed_i (signed_q),
                .a_i         (a_h[i][j]),
                .a_valid_i   (av_h[i][j]),
                .b_i         (b_v[i][j]),
                .b_valid_i   (bv_v[i][j]),
                .a_o         (a_nx),
                .a_valid_o   (a_nx_v),
                .b_o         (b_nx),
                .b_valid_o   (b_nx_v),
                .acc_o       (acc[i][j])
            );

            // Operands leaving the right and bottom edges have no consumer.
            if (j < N - 1) begin : g_right
                assign a_h[i][j+1]  = a_nx;
                assign av_h[i][j+1] = a_nx_v;
            end else begin : g_right_edge
                logic [DATA_WIDTH:0] edge_unused;
                assign edge_unused = {a_nx_v, a_nx};
            end

            if (i < M - 1) begin : g_down
                assign b_v[i+1][j]  = b_nx;
                assign bv_v[i+1][j] = b_nx_v;
            end else begin : g_down_edge
                logic [DATA_WIDTH:0] edge_unused;
                assign edge_unused = {b_nx_v, b_nx};
            end
        end
    end

    // ---------------- result row mux ----------------
    always_comb begin
        out_row = '0;
        if (out_valid) begin
            for (int j = 0; j < N; j++) begin
                out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_q][j];
            end
        end
    end

endmodule

// File: doc/systolic_gemm_tile.md
SYSTOLIC_GEMM_TILE -- requirements
Module: systolic_gemm_tile

Interface
REQ-001 SHALL have parameter M, default 4: PE rows, which is the number of rows of A and C.
REQ-002 SHALL have parameter N, default 4: PE columns, which is the number of columns of B and C.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: the width of each A/B element.
REQ-004 SHALL have parameter ACC_WIDTH, default 32: the width of each C accumulator.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: an operand beat is offered.
REQ-008 SHALL have port in_ready, output, 1 bit: the tile accepts an operand beat.
REQ-009 SHALL have port in_a, input, M*DATA_WIDTH bits: one column k of A, with element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port in_b, input, N*DATA_WIDTH bits: one row k of B, with element j at bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port in_last, input, 1 bit: marks the final k beat of the job.
REQ-012 SHALL have port is_signed, input, 1 bit: 1 selects two's-complement operands and 0 selects unsigned, sampled on the first beat.
REQ-013 SHALL have port acc_keep, input, 1 bit: 1 keeps the previous C and accumulates onto it, sampled on the first beat.
REQ-014 SHALL have port out_valid, output, 1 bit: a result row is presented.
REQ-015 SHALL have port out_ready, input, 1 bit: the consumer accepts the result row.
REQ-016 SHALL have port out_row, output, N*ACC_WIDTH bits: row r of C, with element j at bits [j*ACC_WIDTH +: ACC_WIDTH].
REQ-017 SHALL have port out_last, output, 1 bit: asserted with row M-1.

Function
REQ-018 SHALL be an output-stationary M x N PE grid computing C = A x B over a job of K >= 1 beats, with K unbounded.
REQ-019 SHALL transfer an operand beat when in_valid && in_ready, and a result row when out_valid && out_ready.
REQ-020 SHALL have states IDLE, LOAD, FLUSH and DRAIN.
REQ-021 SHALL drive in_ready = 1 in IDLE and LOAD, and 0 in FLUSH and DRAIN.
REQ-022 SHALL transition on the first beat in IDLE: latch is_signed and acc_keep, and if acc_keep = 0 clear all accumulators in that cycle.
REQ-023 SHALL go to LOAD after the first beat if in_last = 0, and to FLUSH if in_last = 1, including the K = 1 case.
REQ-024 SHALL stay in LOAD until a beat with in_last = 1 is accepted, then go to FLUSH.
REQ-025 SHALL allow in_valid gaps in LOAD, inserting bubbles with no accumulation.
REQ-026 SHALL apply input skew: in_a element i is delayed i cycles and in_b element j is delayed j cycles, each skewed word carrying a valid bit.
REQ-027 SHALL have each PE register its A operand rightward and its B operand downward.
REQ-028 SHALL have PE(i,j) add a*b to its accumulator only when its incoming valid bit is 1.
REQ-029 SHALL have PE(i,j) consume beat k exactly i+j+1 cycles after acceptance, in the absence of bubbles.
REQ-030 SHALL sign-extend or zero-extend each product to ACC_WIDTH according to the latched mode.
REQ-031 SHALL wrap the accumulation modulo 2^ACC_WIDTH, with no saturation.
REQ-032 SHALL remain in FLUSH for exactly M+N-1 cycles, counted by a flush counter, then enter DRAIN.
REQ-033 SHALL assert out_valid throughout DRAIN and present rows r = 0..M-1 in order, advancing only on handshake.
REQ-034 SHALL hold out_row and out_last stable while out_valid && !out_ready.
REQ-035 SHALL return to IDLE after the row M-1 handshake, with in_ready = 1 on the next cycle.
REQ-036 SHALL keep the accumulators in IDLE until the next job, so that acc_keep = 1 extends them.
REQ-037 SHALL ignore in_last, is_signed and acc_keep when in_valid = 0.
REQ-038 SHALL treat M = 1 or N = 1 as legal, with the skew depth for that dimension being 0.

Reset
REQ-039 SHALL, while reset = 1 at a clock edge, enter IDLE.
REQ-040 SHALL clear all accumulators, skew registers, valid bits and counters under reset.
REQ-041 SHALL drive out_valid = 0, out_last = 0, out_row = 0 and in_ready = 0 while reset is held.
REQ-042 SHALL drive in_ready = 1 on the first cycle after reset deasserts.
REQ-043 SHALL discard any job in progress when reset occurs mid-job, in any state, producing no partial output.

Structure
REQ-044 SHALL place the state enum and the default parameter constants in a shared package, gemm_pkg.
REQ-045 SHALL use one sub-module, gemm_pe, containing the operand pass-through registers, the valid pass-through, the MAC and the accumulator, instantiated M*N times via generate.

Verification
REQ-046 SHALL cover an identity product: M=N=4, K=4, A = I, B = rows {1,2,3,4}, signed -> rows out {1,2,3,4}x4 in order, with out_last on row 3.
REQ-047 SHALL cover signed/unsigned modes: K=1, a = 8'hFF, b = 8'h02 everywhere -> signed C = -2 (32'hFFFFFFFE) and unsigned C = 510.
REQ-048 SHALL cover accumulation across jobs: job 1 with K=2 and all ones -> C = 2, then job 2 with acc_keep = 1 and the same data -> C = 4.
REQ-049 SHALL cover backpressure and bubbles: in_valid toggled every other cycle in LOAD and out_ready held 0 for 5 cycles in DRAIN -> results identical to the no-stall case and out_row stable during the stall.
REQ-050 SHALL cover wrap-around: ACC_WIDTH = 16, 3 beats of 127*127 unsigned -> C = 48387 mod 65536 = 48387, then a 5th-beat job -> C = 80645 mod 65536 = 15109.
REQ-051 SHALL cover reset mid-job: reset asserted in FLUSH -> out_valid never asserts, and a following job with acc_keep = 1 and K=1 of ones gives C = 1.
